// File: rtl/tdm_demux41b.sv
// ---------------------------------------------------------------------------
// tdm_demux41b
// Receive end of a 4:1 time-division link. One lane arrives per beat, and
// in_sof marks slot 0. The block tracks the slot locally and assembles the
// lanes into a word. Each complete frame is offered to a registered
// valid/ready output stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a beat is present on in_data (always taken, no backpressure)
//   in_sof     the beat is slot 0 of a frame (ignored when in_valid=0)
//   in_data    lane payload, W bits
//   out_word   assembled frame, lane k at out_word[k*W +: W]
//   out_valid  out_word holds a frame that has not been consumed yet
//   out_ready  consumer takes out_word when out_valid && out_ready
//   slot       next expected slot index (debug)
//   sync_err   one-cycle pulse: in_sof arrived in the middle of a frame
//   overrun    one-cycle pulse: a completed frame was dropped (output full)
// ---------------------------------------------------------------------------
module tdm_demux41b #(
   parameter int W  = 1,
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   input  logic           in_sof,
   input  logic [W-1:0]   in_data,
   output logic [N*W-1:0] out_word,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [SW-1:0]  slot,
   output logic           sync_err,
   output logic           overrun
);

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    slot_q, slot_d;
   logic [N*W-1:0]   asm_q, asm_d;
   logic [N*W-1:0]   outWord_q, outWord_d;
   logic             outValid_q, outValid_d;
   logic             syncErr_q, syncErr_d;
   logic             overrun_q, overrun_d;
   logic             frameDone;

   // Frame assembly and slot tracking.
   // HUNT throws beats away until it sees a start of frame. COLLECT writes
   // each beat into the lane named by the slot counter. If a start of frame
   // arrives in the middle of a frame, the partial frame is abandoned. That
   // beat becomes lane 0 of a fresh frame, so the block resyncs without
   // losing it. When the beat for the last slot is written, frameDone is
   // raised. asm_d already contains that beat, so the output stage sees the
   // whole frame on the same edge.
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      asm_d     = asm_q;
      syncErr_d = 1'b0;
      frameDone = 1'b0;
      unique case (state_q)
         HUNT: begin
            if (in_valid && in_sof) begin
               asm_d[0 +: W] = in_data;
               slot_d        = SW'(1);
               state_d       = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid) begin
               if (in_sof) begin
                  syncErr_d     = 1'b1;
                  asm_d[0 +: W] = in_data;
                  slot_d        = SW'(1);
               end else begin
                  asm_d[slot_q*W +: W] = in_data;
                  if (slot_q == SW'(N-1)) begin
                     slot_d    = '0;
                     state_d   = HUNT;
                     frameDone = 1'b1;
                  end else begin
                     slot_d = slot_q + SW'(1);
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Output holding register.
   // A completed frame loads when the register is empty, or when the
   // register is being drained on this very edge. A consumer handshake on
   // the completion edge therefore swaps in the new word with no bubble.
   // If the register is full and not draining, the new frame is dropped,
   // the old word stays, and overrun pulses.
   always_comb begin
      outWord_d  = outWord_q;
      outValid_d = outValid_q;
      overrun_d  = 1'b0;
      if (frameDone) begin
         if (!outValid_q || out_ready) begin
            outWord_d  = asm_d;
            outValid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // All state is cleared by the asynchronous reset. A partial frame that
   // is in progress when reset asserts is discarded along with everything
   // else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         slot_q     <= '0;
         asm_q      <= '0;
         outWord_q  <= '0;
         outValid_q <= 1'b0;
         syncErr_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         asm_q      <= asm_d;
         outWord_q  <= outWord_d;
         outValid_q <= outValid_d;
         syncErr_q  <= syncErr_d;
         overrun_q  <= overrun_d;
      end
   end

   assign out_word  = outWord_q;
   assign out_valid = outValid_q;
   assign slot      = slot_q;
   assign sync_err  = syncErr_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_demux41b.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux41b
// Self-checking bench for tdm_demux41b with W=1 and N=4.
//
// The reference model keeps the frame being received as a queue of beats.
// The expected slot is simply the length of that queue. A frame completes
// when the queue reaches N beats. The scoreboard queue holds frames that
// the consumer has not taken yet, so the output register counts as full
// exactly when the scoreboard is non-empty.
//
// A monitor on the falling edge compares the DUT against the model every
// cycle. When a handshake is due on the next edge, it pops the scoreboard.
// ---------------------------------------------------------------------------
module tb_tdm_demux41b;

   localparam int W  = 1;
   localparam int N  = 4;
   localparam int SW = 2;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_sof;
   logic [W-1:0]   in_data;
   logic [N*W-1:0] out_word;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  slot;
   logic           sync_err;
   logic           overrun;

   int checks   = 0;
   int failures = 0;

   logic           frameQ[$];
   logic [N*W-1:0] sbQ[$];
   logic           expSyncErr = 1'b0;
   logic           expOverrun = 1'b0;
   logic [N*W-1:0] lastPopped = '0;
   int             overrunSeen = 0;
   int             syncErrSeen = 0;

   tdm_demux41b #(.W(W), .N(N), .SW(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .out_word  (out_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .slot      (slot),
      .sync_err  (sync_err),
      .overrun   (overrun)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against the expected value, and count it.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one beat plus the ready level. Then wait for the edge that
   // samples them, plus a small offset so inputs never change on the edge.
   task automatic applyStimulus(input logic v, input logic sof, input logic d, input logic rdy);
      in_valid  = v;
      in_sof    = sof;
      in_data   = d;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference model. It is updated on each rising edge from
   // the inputs sampled there, and cleared by reset.
   // A start of frame replaces whatever has been collected. If something
   // was collected, that is a sync error. Beats without a start of frame
   // only count once a frame has begun. When N beats have been collected,
   // the frame is packed into a word. It goes to the scoreboard if the
   // consumer has drained the previous word, and is dropped otherwise.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frameQ.delete();
         sbQ.delete();
         expSyncErr = 1'b0;
         expOverrun = 1'b0;
      end else begin
         expSyncErr = 1'b0;
         expOverrun = 1'b0;
         if (in_valid) begin
            if (in_sof) begin
               expSyncErr = (frameQ.size() != 0);
               frameQ.delete();
               frameQ.push_back(in_data[0]);
            end else if (frameQ.size() != 0) begin
               frameQ.push_back(in_data[0]);
            end
            if (frameQ.size() == N) begin
               logic [N*W-1:0] w;
               for (int k = 0; k < N; k++) w[k] = frameQ[k];
               frameQ.delete();
               if (sbQ.size() == 0) sbQ.push_back(w);
               else expOverrun = 1'b1;
            end
         end
      end
   end

   // Monitor: every falling edge, compare the DUT outputs with the model.
   // The ready level is stable here until the next rising edge. So when
   // the scoreboard holds a word and ready is high, this is the word that
   // will be consumed on that edge, and it is popped now.
   always @(negedge clk) begin
      checkOutput("slot", 32'(slot), 32'(frameQ.size()));
      checkOutput("sync_err", 32'(sync_err), 32'(expSyncErr));
      checkOutput("overrun", 32'(overrun), 32'(expOverrun));
      checkOutput("out_valid", 32'(out_valid), 32'(sbQ.size() != 0));
      if (overrun) overrunSeen++;
      if (sync_err) syncErrSeen++;
      if (sbQ.size() != 0) begin
         checkOutput("out_word", 32'(out_word), 32'(sbQ[0]));
         if (out_ready) lastPopped = sbQ.pop_front();
      end
   end

   // Stimulus: reset, then the directed scenarios, then a randomized run.
   initial begin
      int ovBase;
      int seBase;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #12;
      checkOutput("reset out_word", 32'(out_word), 32'h0);
      checkOutput("reset out_valid", 32'(out_valid), 32'h0);
      checkOutput("reset slot", 32'(slot), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] T1 basic frame");
      applyStimulus(1, 1, 1, 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("T1 word", 32'(lastPopped), 32'hD);

      $display("[TB] T2 hunt and gaps");
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(1, 1, 1, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("T2 word", 32'(lastPopped), 32'h3);

      $display("[TB] T3 resync");
      seBase = syncErrSeen;
      applyStimulus(1, 1, 1, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(1, 1, 0, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("T3 word", 32'(lastPopped), 32'h6);
      checkOutput("T3 sync_err count", 32'(syncErrSeen - seBase), 32'd1);

      $display("[TB] T4 overrun");
      ovBase = overrunSeen;
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 1, 1, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("T4 held word", 32'(out_word), 32'hA);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("T4 overrun count", 32'(overrunSeen - ovBase), 32'd1);
      checkOutput("T4 word", 32'(lastPopped), 32'hA);
      checkOutput("T4 drained", 32'(out_valid), 32'h0);

      $display("[TB] T5 handshake on completion");
      ovBase = overrunSeen;
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 1, 1, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 0, 0, 1);
      checkOutput("T5 word", 32'(out_word), 32'h5);
      checkOutput("T5 valid", 32'(out_valid), 32'h1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("T5 overrun count", 32'(overrunSeen - ovBase), 32'd0);

      $display("[TB] T6 async reset mid-frame");
      applyStimulus(1, 1, 1, 0);
      applyStimulus(1, 0, 0, 0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("T6 out_word", 32'(out_word), 32'h0);
      checkOutput("T6 out_valid", 32'(out_valid), 32'h0);
      checkOutput("T6 slot", 32'(slot), 32'h0);
      checkOutput("T6 sync_err", 32'(sync_err), 32'h0);
      checkOutput("T6 overrun", 32'(overrun), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1, 1, 1, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(1, 0, 1, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("T6 word", 32'(lastPopped), 32'hF);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         logic v, sof, d, rdy;
         v   = ($urandom_range(0, 3) != 0);
         sof = (frameQ.size() == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
         d   = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 2) != 0);
         applyStimulus(v, sof, d, rdy);
      end
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
